sf_trace_capture: RTL and testbench
===================================

SF_TRACE_CAPTURE -- requirements
Module: sf_trace_capture

Interface
REQ-001 SHALL have parameter pw, default 18, meaning base sample width.
REQ-002 SHALL have parameter extra, default 4, meaning trace headroom bits; the stored word width is tw = pw+extra.
REQ-003 SHALL have parameter aw, default 6, meaning buffer address width; depth is N = 2^aw.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-006 SHALL have port ce, input, 1, clock enable for the capture path.
REQ-007 SHALL have port trace, input, tw signed, sample stream from the sf_user state machine.
REQ-008 SHALL have port trace_strobe, input, 1, marks trace valid (qualified by ce).
REQ-009 SHALL have port arm, input, 1, single-cycle start/restart pulse from the host (qualified by ce).
REQ-010 SHALL have port h_addr, input, aw, host read address.
REQ-011 SHALL have port h_data, output, tw signed, host read data.
REQ-012 SHALL have port done, output, 1, set when the buffer is full.
REQ-013 SHALL have port count, output, aw+1, number of samples captured since the last arm.
REQ-014 SHALL have port overflow, output, 8, strobes dropped while done, saturating.

Function
REQ-015 SHALL have states IDLE, CAPTURE and DONE.
REQ-016 SHALL move from IDLE to CAPTURE on the first clk with ce&arm; any strobe in that cycle SHALL NOT be stored.
REQ-017 In CAPTURE, each ce&trace_strobe SHALL write trace to mem[count[aw-1:0]] and increment count on the same edge.
REQ-018 When the write that makes count reach N occurs, the FSM SHALL enter DONE and assert done on the same edge.
REQ-019 In DONE, each ce&trace_strobe SHALL increment overflow, saturating at 255, and SHALL NOT write memory.
REQ-020 In DONE, memory contents SHALL be frozen.
REQ-021 A ce&arm in CAPTURE or DONE SHALL restart the capture: count=0, overflow=0, done=0, state=CAPTURE.
REQ-022 A strobe coinciding with a restart arm SHALL be discarded, because arm has priority.
REQ-023 When ce=0, the FSM, count, overflow and memory SHALL hold.
REQ-024 h_data SHALL be mem[h_addr] registered once, giving 1-clk latency every clk, independent of ce and state, matching sf_dpram read timing.
REQ-025 A host read of the address being written in the same cycle SHALL return the old contents.
REQ-026 Reads during CAPTURE are permitted; h_data SHALL reflect the memory state at the read edge.
REQ-027 Memory SHALL be a simple dual-port RAM (one write port, one read port), inferable as block RAM.
REQ-028 count SHALL never exceed N; the write address SHALL never wrap in CAPTURE.

Reset
REQ-029 While rst_n=0 (asynchronously), the FSM SHALL be in IDLE with count=0, done=0, overflow=0 and h_data=0.
REQ-030 Memory contents SHALL NOT be reset and are undefined until written.
REQ-031 Deassertion of rst_n SHALL take effect synchronously on the next clk edge.
REQ-032 Reset mid-CAPTURE SHALL abandon the capture; a new arm SHALL be required.
REQ-033 In IDLE, strobes SHALL be ignored and count SHALL stay 0.

Verification
REQ-034 Basic fill: reset, arm, 64 strobes with trace=k-32 (k=0..63), then read addr 0..63 -> h_data equals k-32 one clk after each address; count=64; done=1 on the 64th strobe edge.
REQ-035 Overflow saturation: after done, 300 further strobes -> overflow=255; mem[0..63] unchanged.
REQ-036 Restart: arm after 10 strobes -> count=0; the next 5 strobes land at addr 0..4; done=0; a strobe in the arm cycle is not stored.
REQ-037 ce gating: strobes with ce=0 interleaved 1:1 with ce=1 strobes -> only the ce=1 samples are stored, in order.
REQ-038 Read/write collision: read addr 3 in the same cycle as the 4th write (value 0x1234) -> returns old data; a read on the next cycle returns 0x1234.
REQ-039 Async reset mid-capture at count=20 -> count=0, done=0 and h_data=0 immediately; strobes ignored until arm.

Source files
------------

// File: rtl/sf_trace_capture.sv
// Trace capture buffer: arm, then fill an N-deep RAM from strobed samples.
// Once the buffer is full, further strobes are only counted as overflow.
module sf_trace_capture #(
  parameter int pw    = 18,
  parameter int extra = 4,
  parameter int aw    = 6,
  localparam int tw   = pw + extra
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic signed [tw-1:0] trace,
  input  logic                 trace_strobe,
  input  logic                 arm,
  input  logic [aw-1:0]        h_addr,
  output logic signed [tw-1:0] h_data,
  output logic                 done,
  output logic [aw:0]          count,
  output logic [7:0]           overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [aw:0]        count_reg, count_next;
  logic [7:0]         overflow_reg, overflow_next;
  logic               wr_en;
  logic signed [tw-1:0] mem [0:(1<<aw)-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      overflow_reg <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Arm wins over any strobe in the same cycle; nothing moves without ce.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    wr_en         = 1'b0;
    if (ce) begin
      if (arm) begin
        state_next    = CAPTURE;
        count_next    = '0;
        overflow_next = '0;
      end else begin
        case (state_reg)
          CAPTURE: begin
            if (trace_strobe) begin
              wr_en      = 1'b1;
              count_next = count_reg + 1'b1;
              // Last free slot: count reaches N on this edge, so stop here.
              if (&count_reg[aw-1:0])
                state_next = DONE;
            end
          end
          DONE: begin
            if (trace_strobe && (overflow_reg != 8'hff))
              overflow_next = overflow_reg + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Simple dual-port RAM: no reset on the array so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[count_reg[aw-1:0]] <= trace;
  end

  // Read register sees pre-write contents on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      h_data <= '0;
    else
      h_data <= mem[h_addr];
  end

  assign done     = (state_reg == DONE);
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_sf_trace_capture.sv
// Directed bench for sf_trace_capture: fill, overflow, restart, ce gating,
// read/write collision and asynchronous reset mid-capture.
module tb_sf_trace_capture;

  localparam int pw    = 18;
  localparam int extra = 4;
  localparam int aw    = 6;
  localparam int tw    = pw + extra;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ce;
  logic signed [tw-1:0] trace;
  logic                 trace_strobe;
  logic                 arm;
  logic [aw-1:0]        h_addr;
  logic signed [tw-1:0] h_data;
  logic                 done;
  logic [aw:0]          count;
  logic [7:0]           overflow;

  int vec_count  = 0;
  int miscompares = 0;

  sf_trace_capture #(.pw(pw), .extra(extra), .aw(aw)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .trace        (trace),
    .trace_strobe (trace_strobe),
    .arm          (arm),
    .h_addr       (h_addr),
    .h_data       (h_data),
    .done         (done),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input int got, input int exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      trace        = tw'(base + i);
      trace_strobe = 1'b1;
      step();
    end
    trace_strobe = 1'b0;
  endtask

  task automatic do_arm(input logic with_strobe, input int val);
    arm          = 1'b1;
    trace_strobe = with_strobe;
    trace        = tw'(val);
    step();
    arm          = 1'b0;
    trace_strobe = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int addr, input int exp);
    h_addr = aw'(addr);
    step();
    check_vec(tag, int'(h_data), exp);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; trace = '0; trace_strobe = 1'b0;
    arm = 1'b0; h_addr = '0;
    step(); step();
    check_vec("rst_count", int'(count), 0);
    check_vec("rst_done", int'(done), 0);
    check_vec("rst_overflow", int'(overflow), 0);
    check_vec("rst_hdata", int'(h_data), 0);
    rst_n = 1'b1;
    step();

    // Basic fill; the strobe in the arm cycle must be discarded
    ce = 1'b1;
    do_arm(1'b1, 999);
    check_vec("arm_count", int'(count), 0);
    for (int k = 0; k < 64; k++) begin
      trace = tw'(k - 32);
      trace_strobe = 1'b1;
      step();
      if (k == 62) check_vec("fill_done_early", int'(done), 0);
    end
    trace_strobe = 1'b0;
    check_vec("fill_done", int'(done), 1);
    check_vec("fill_count", int'(count), 64);
    for (int a = 0; a < 64; a++)
      read_chk($sformatf("fill_rd%0d", a), a, a - 32);

    // Overflow saturation with memory frozen
    strobe_n(300, 7);
    check_vec("ovf_sat", int'(overflow), 255);
    check_vec("ovf_count", int'(count), 64);
    check_vec("ovf_done", int'(done), 1);
    read_chk("ovf_rd0", 0, -32);
    read_chk("ovf_rd31", 31, -1);
    read_chk("ovf_rd63", 63, 31);

    // Restart after 10 strobes; arm-cycle strobe dropped
    do_arm(1'b0, 0);
    check_vec("rearm_ovf", int'(overflow), 0);
    strobe_n(10, 100);
    check_vec("pre_restart_count", int'(count), 10);
    do_arm(1'b1, 555);
    check_vec("restart_count", int'(count), 0);
    check_vec("restart_done", int'(done), 0);
    strobe_n(5, 200);
    check_vec("restart_count5", int'(count), 5);
    for (int a = 0; a < 5; a++)
      read_chk($sformatf("restart_rd%0d", a), a, 200 + a);
    read_chk("restart_rd5_old", 5, 105);

    // ce gating: only even (ce=1) samples stored
    do_arm(1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      ce = (i % 2 == 0);
      arm = (i == 3);
      trace = tw'(300 + i);
      trace_strobe = 1'b1;
      step();
    end
    trace_strobe = 1'b0; arm = 1'b0;
    ce = 1'b0;
    check_vec("ce_count", int'(count), 4);
    for (int a = 0; a < 4; a++)
      read_chk($sformatf("ce_rd%0d", a), a, 300 + 2 * a);
    ce = 1'b1;

    // Read/write collision at address 3
    do_arm(1'b0, 0);
    strobe_n(3, 1);
    h_addr = 3;
    trace = tw'(32'h1234);
    trace_strobe = 1'b1;
    step();
    trace_strobe = 1'b0;
    check_vec("coll_old", int'(h_data), 306);
    step();
    check_vec("coll_new", int'(h_data), 32'h1234);

    // Asynchronous reset mid-capture
    do_arm(1'b0, 0);
    strobe_n(20, 400);
    check_vec("mid_count", int'(count), 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("arst_count", int'(count), 0);
    check_vec("arst_done", int'(done), 0);
    check_vec("arst_hdata", int'(h_data), 0);
    step();
    rst_n = 1'b1;
    strobe_n(5, 500);
    check_vec("post_rst_count", int'(count), 0);
    check_vec("post_rst_done", int'(done), 0);
    do_arm(1'b0, 0);
    strobe_n(1, 600);
    check_vec("post_rst_arm_count", int'(count), 1);
    read_chk("post_rst_rd0", 0, 600);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
